// File: rtl/pong_vga_pkg.sv
// Default 640x480@60 timing constants and the porch compare shared by the Pong VGA stages.
package pong_vga_pkg;

    localparam int unsigned VgaTotalCols   = 800;
    localparam int unsigned VgaTotalRows   = 525;
    localparam int unsigned VgaActiveCols  = 640;
    localparam int unsigned VgaActiveRows  = 480;
    localparam int unsigned VgaHFrontPorch = 16;
    localparam int unsigned VgaHBackPorch  = 48;
    localparam int unsigned VgaVFrontPorch = 10;
    localparam int unsigned VgaVBackPorch  = 33;
    localparam int unsigned VgaVideoWidth  = 3;

    // Idle (high) level of an active-low sync: low only between the front and back porches.
    function automatic logic sync_level(input int unsigned pos, input int unsigned active,
                                        input int unsigned front_porch,
                                        input int unsigned back_porch,
                                        input int unsigned total);
        return (pos < active + front_porch) || (pos > total - back_porch - 1);
    endfunction

endpackage

// File: rtl/pong_sync_counter.sv
// Edge-detects the upstream Vsync window, runs col/row counters aligned with the delayed
// syncs, and reports whether a frame start has been seen since reset.
module pong_sync_counter
    import pong_vga_pkg::*;
#(
    parameter int unsigned TOTAL_COLS = VgaTotalCols,
    parameter int unsigned TOTAL_ROWS = VgaTotalRows
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          hsync_i,
    input  logic                          vsync_i,
    output logic                          hsync_dly_o,
    output logic                          vsync_dly_o,
    output logic [$clog2(TOTAL_COLS)-1:0] col_o,
    output logic [$clog2(TOTAL_ROWS)-1:0] row_o,
    output logic                          locked_o
);

    localparam int unsigned ColW = $clog2(TOTAL_COLS);
    localparam int unsigned RowW = $clog2(TOTAL_ROWS);

    logic [ColW-1:0] col_q;
    logic [RowW-1:0] row_q;
    logic            hsync_q;
    logic            vsync_q;
    logic            locked_q;
    logic            frame_start;

    assign frame_start = vsync_i & ~vsync_q;

    // Delay the syncs one clock and count pixels; a Vsync rise always re-zeroes the counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
            locked_q <= 1'b0;
        end else begin
            hsync_q <= hsync_i;
            vsync_q <= vsync_i;
            if (frame_start) begin
                col_q    <= '0;
                row_q    <= '0;
                locked_q <= 1'b1;
            end else if (col_q == ColW'(TOTAL_COLS - 1)) begin
                col_q <= '0;
                row_q <= (row_q == RowW'(TOTAL_ROWS - 1)) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign hsync_dly_o = hsync_q;
    assign vsync_dly_o = vsync_q;
    assign col_o       = col_q;
    assign row_o       = row_q;
    assign locked_o    = locked_q;

endmodule

// File: rtl/pong_sync_porch.sv
// Converts Pong's active-window syncs into porched, active-low VGA syncs and blanks the video,
// keeping syncs and video at the same two-clock latency from the inputs.
module pong_sync_porch
    import pong_vga_pkg::*;
#(
    parameter int unsigned TOTAL_COLS    = VgaTotalCols,
    parameter int unsigned TOTAL_ROWS    = VgaTotalRows,
    parameter int unsigned ACTIVE_COLS   = VgaActiveCols,
    parameter int unsigned ACTIVE_ROWS   = VgaActiveRows,
    parameter int unsigned H_FRONT_PORCH = VgaHFrontPorch,
    parameter int unsigned H_BACK_PORCH  = VgaHBackPorch,
    parameter int unsigned V_FRONT_PORCH = VgaVFrontPorch,
    parameter int unsigned V_BACK_PORCH  = VgaVBackPorch,
    parameter int unsigned VIDEO_WIDTH   = VgaVideoWidth
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   Hsync_i,
    input  logic                   Vsync_i,
    input  logic [VIDEO_WIDTH-1:0] Red_Video_i,
    input  logic [VIDEO_WIDTH-1:0] Grn_Video_i,
    input  logic [VIDEO_WIDTH-1:0] Blu_Video_i,
    output logic                   Hsync_o,
    output logic                   Vsync_o,
    output logic [VIDEO_WIDTH-1:0] Red_Video_o,
    output logic [VIDEO_WIDTH-1:0] Grn_Video_o,
    output logic [VIDEO_WIDTH-1:0] Blu_Video_o,
    output logic                   Locked_o
);

    localparam int unsigned ColW = $clog2(TOTAL_COLS);
    localparam int unsigned RowW = $clog2(TOTAL_ROWS);

    logic            hsync_dly;
    logic            vsync_dly;
    logic            locked;
    logic [ColW-1:0] col;
    logic [RowW-1:0] row;

    logic [VIDEO_WIDTH-1:0] red_q;
    logic [VIDEO_WIDTH-1:0] grn_q;
    logic [VIDEO_WIDTH-1:0] blu_q;

    logic hsync_lvl;
    logic vsync_lvl;
    logic visible;

    pong_sync_counter #(
        .TOTAL_COLS (TOTAL_COLS),
        .TOTAL_ROWS (TOTAL_ROWS)
    ) u_counter (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .hsync_i     (Hsync_i),
        .vsync_i     (Vsync_i),
        .hsync_dly_o (hsync_dly),
        .vsync_dly_o (vsync_dly),
        .col_o       (col),
        .row_o       (row),
        .locked_o    (locked)
    );

    assign Locked_o = locked;

    // Porch compare on the counters; visibility comes from the delayed upstream window syncs.
    always_comb begin
        hsync_lvl = sync_level(32'(col), ACTIVE_COLS, H_FRONT_PORCH, H_BACK_PORCH, TOTAL_COLS);
        vsync_lvl = sync_level(32'(row), ACTIVE_ROWS, V_FRONT_PORCH, V_BACK_PORCH, TOTAL_ROWS);
        visible   = hsync_dly & vsync_dly;
    end

    // Second pipeline stage: registered syncs plus blanked video, held idle until locked.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            red_q       <= '0;
            grn_q       <= '0;
            blu_q       <= '0;
            Hsync_o     <= 1'b1;
            Vsync_o     <= 1'b1;
            Red_Video_o <= '0;
            Grn_Video_o <= '0;
            Blu_Video_o <= '0;
        end else begin
            red_q <= Red_Video_i;
            grn_q <= Grn_Video_i;
            blu_q <= Blu_Video_i;
            if (locked) begin
                Hsync_o     <= hsync_lvl;
                Vsync_o     <= vsync_lvl;
                Red_Video_o <= visible ? red_q : '0;
                Grn_Video_o <= visible ? grn_q : '0;
                Blu_Video_o <= visible ? blu_q : '0;
            end else begin
                Hsync_o     <= 1'b1;
                Vsync_o     <= 1'b1;
                Red_Video_o <= '0;
                Grn_Video_o <= '0;
                Blu_Video_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pong_sync_porch.sv
// Directed bench for pong_sync_porch: an upstream col/row model drives the window syncs.
// Horizontal timing is the 640x480 default; vertical timing is shortened (14 rows, 8 visible,
// Vsync pulse on rows 10..11) so whole frames fit in a short run.
module tb_pong_sync_porch;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       Hsync_i, Vsync_i;
    logic [2:0] Red_Video_i, Grn_Video_i, Blu_Video_i;
    logic       Hsync_o, Vsync_o, Locked_o;
    logic [2:0] Red_Video_o, Grn_Video_o, Blu_Video_o;

    int errors = 0;
    int checks = 0;

    int         ucol = 0;
    int         urow = 0;
    bit         gen  = 1'b0;
    logic [2:0] red_c, grn_c, blu_c;

    pong_sync_porch #(
        .TOTAL_ROWS    (14),
        .ACTIVE_ROWS   (8),
        .V_FRONT_PORCH (2),
        .V_BACK_PORCH  (2)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .Hsync_i     (Hsync_i),
        .Vsync_i     (Vsync_i),
        .Red_Video_i (Red_Video_i),
        .Grn_Video_i (Grn_Video_i),
        .Blu_Video_i (Blu_Video_i),
        .Hsync_o     (Hsync_o),
        .Vsync_o     (Vsync_o),
        .Red_Video_o (Red_Video_o),
        .Grn_Video_o (Grn_Video_o),
        .Blu_Video_o (Blu_Video_o),
        .Locked_o    (Locked_o)
    );

    always #20 clk = ~clk;

    // Present the upstream position, clock once, sample 1 time unit later, advance the model.
    task automatic tick();
        if (gen) begin
            Hsync_i     = (ucol < 640);
            Vsync_i     = (urow < 8);
            Red_Video_i = red_c;
            Grn_Video_i = grn_c;
            Blu_Video_i = blu_c;
        end else begin
            Hsync_i     = 1'b0;
            Vsync_i     = 1'b0;
            Red_Video_i = 3'b000;
            Grn_Video_i = 3'b000;
            Blu_Video_i = 3'b000;
        end
        @(posedge clk);
        #1;
        if (gen) begin
            if (ucol == 799) begin
                ucol = 0;
                urow = (urow == 13) ? 0 : urow + 1;
            end else begin
                ucol++;
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        gen   = 1'b0;
        repeat (5) tick();
        checks++;
        if (Locked_o !== 1'b0) begin
            errors++; $display("FAIL reset_locked: got %b want 0", Locked_o);
        end
        checks++;
        if (Hsync_o !== 1'b1) begin
            errors++; $display("FAIL reset_hsync: got %b want 1", Hsync_o);
        end
        checks++;
        if (Vsync_o !== 1'b1) begin
            errors++; $display("FAIL reset_vsync: got %b want 1", Vsync_o);
        end
        checks++;
        if ({Red_Video_o, Grn_Video_o, Blu_Video_o} !== 9'd0) begin
            errors++; $display("FAIL reset_video: got %b want 0",
                               {Red_Video_o, Grn_Video_o, Blu_Video_o});
        end
        rst_i = 1'b0;
        repeat (3) tick();
        checks++;
        if (Locked_o !== 1'b0) begin
            errors++; $display("FAIL idle_locked: got %b want 0", Locked_o);
        end
        checks++;
        if (Hsync_o !== 1'b1) begin
            errors++; $display("FAIL idle_hsync: got %b want 1", Hsync_o);
        end
        checks++;
        if (Vsync_o !== 1'b1) begin
            errors++; $display("FAIL idle_vsync: got %b want 1", Vsync_o);
        end
        checks++;
        if ({Red_Video_o, Grn_Video_o, Blu_Video_o} !== 9'd0) begin
            errors++; $display("FAIL idle_video: got %b want 0",
                               {Red_Video_o, Grn_Video_o, Blu_Video_o});
        end
    endtask

    // Row 0 of the first frame: Hsync_o low from tick 658 for 96 ticks.
    task automatic test_hsync();
        int first_low = -1;
        int lows      = 0;
        red_c = 3'b101; grn_c = 3'b101; blu_c = 3'b101;
        gen = 1'b1; ucol = 0; urow = 0;
        for (int i = 1; i <= 800; i++) begin
            tick();
            if (i == 1) begin
                checks++;
                if (Locked_o !== 1'b1) begin
                    errors++; $display("FAIL lock_first: got %b want 1", Locked_o);
                end
            end
            if (Hsync_o === 1'b0) begin
                lows++;
                if (first_low < 0) first_low = i;
            end
        end
        checks++;
        if (first_low != 658) begin
            errors++; $display("FAIL hsync_start: got %0d want 658", first_low);
        end
        checks++;
        if (lows != 96) begin
            errors++; $display("FAIL hsync_width: got %0d want 96", lows);
        end
    endtask

    // Row 1: colour 101 visible for cols 0..639, i.e. ticks 2..641.
    task automatic test_video();
        int first = -1;
        int rc = 0, gc = 0, bc = 0;
        for (int i = 1; i <= 800; i++) begin
            tick();
            if (Red_Video_o === 3'b101) begin
                rc++;
                if (first < 0) first = i;
            end
            if (Grn_Video_o === 3'b101) gc++;
            if (Blu_Video_o === 3'b101) bc++;
        end
        checks++;
        if (first != 2) begin
            errors++; $display("FAIL video_first: got %0d want 2", first);
        end
        checks++;
        if (rc != 640) begin
            errors++; $display("FAIL video_red_count: got %0d want 640", rc);
        end
        checks++;
        if (gc != 640) begin
            errors++; $display("FAIL video_grn_count: got %0d want 640", gc);
        end
        checks++;
        if (bc != 640) begin
            errors++; $display("FAIL video_blu_count: got %0d want 640", bc);
        end
    endtask

    // Rows 2..13: row 10 col 0 is 6400 positions after row 2 col 0, seen on tick 6402.
    task automatic test_vsync();
        int first_low = -1;
        int lows      = 0;
        int vis       = 0;
        for (int i = 1; i <= 9600; i++) begin
            tick();
            if (Vsync_o === 1'b0) begin
                lows++;
                if (first_low < 0) first_low = i;
            end
            if (Red_Video_o === 3'b101) vis++;
        end
        checks++;
        if (first_low != 6402) begin
            errors++; $display("FAIL vsync_start: got %0d want 6402", first_low);
        end
        checks++;
        if (lows != 1600) begin
            errors++; $display("FAIL vsync_width: got %0d want 1600", lows);
        end
        checks++;
        if (vis != 3840) begin
            errors++; $display("FAIL vblank_count: got %0d want 3840", vis);
        end
    endtask

    // Jump upstream from row 9 col 300 to (0,0): the Vsync_i rise realigns the counters.
    task automatic test_resync();
        int first_low = -1;
        int vlows     = 0;
        for (int n = 0; n < 20000; n++) begin
            if (urow == 9 && ucol == 300) break;
            tick();
        end
        red_c = 3'b011; grn_c = 3'b110; blu_c = 3'b001;
        ucol = 0; urow = 0;
        for (int i = 1; i <= 800; i++) begin
            tick();
            if (i == 2) begin
                checks++;
                if ({Red_Video_o, Grn_Video_o, Blu_Video_o} !== 9'b011_110_001) begin
                    errors++; $display("FAIL resync_video: got %b want 011110001",
                                       {Red_Video_o, Grn_Video_o, Blu_Video_o});
                end
            end
            if (Hsync_o === 1'b0 && first_low < 0) first_low = i;
            if (Vsync_o === 1'b0) vlows++;
        end
        checks++;
        if (first_low != 658) begin
            errors++; $display("FAIL resync_hsync_start: got %0d want 658", first_low);
        end
        checks++;
        if (vlows != 0) begin
            errors++; $display("FAIL resync_vsync_lows: got %0d want 0", vlows);
        end
    endtask

    // Reset at row 6 col 100, held to row 8; stay unlocked until the next frame start.
    task automatic test_reset_midframe();
        int hl = 0, vl = 0, vid = 0, lk = 0;
        int first_low = -1;
        for (int n = 0; n < 20000; n++) begin
            if (urow == 6 && ucol == 100) break;
            tick();
        end
        rst_i = 1'b1;
        tick();
        checks++;
        if (Locked_o !== 1'b0) begin
            errors++; $display("FAIL mid_reset_locked: got %b want 0", Locked_o);
        end
        checks++;
        if (Hsync_o !== 1'b1 || Vsync_o !== 1'b1) begin
            errors++; $display("FAIL mid_reset_syncs: got %b%b want 11", Hsync_o, Vsync_o);
        end
        checks++;
        if ({Red_Video_o, Grn_Video_o, Blu_Video_o} !== 9'd0) begin
            errors++; $display("FAIL mid_reset_video: got %b want 0",
                               {Red_Video_o, Grn_Video_o, Blu_Video_o});
        end
        for (int n = 0; n < 20000; n++) begin
            if (urow == 8 && ucol == 0) break;
            tick();
        end
        rst_i = 1'b0;
        for (int n = 0; n < 20000; n++) begin
            tick();
            if (Hsync_o !== 1'b1) hl++;
            if (Vsync_o !== 1'b1) vl++;
            if ({Red_Video_o, Grn_Video_o, Blu_Video_o} !== 9'd0) vid++;
            if (Locked_o !== 1'b0) lk++;
            if (urow == 0 && ucol == 0) break;
        end
        checks++;
        if (lk != 0) begin
            errors++; $display("FAIL unlocked_locked: got %0d high samples want 0", lk);
        end
        checks++;
        if (hl != 0 || vl != 0) begin
            errors++; $display("FAIL unlocked_syncs: got %0d/%0d low samples want 0/0", hl, vl);
        end
        checks++;
        if (vid != 0) begin
            errors++; $display("FAIL unlocked_video: got %0d nonzero samples want 0", vid);
        end
        for (int i = 1; i <= 800; i++) begin
            tick();
            if (i == 1) begin
                checks++;
                if (Locked_o !== 1'b1) begin
                    errors++; $display("FAIL relock: got %b want 1", Locked_o);
                end
            end
            if (Hsync_o === 1'b0 && first_low < 0) first_low = i;
        end
        checks++;
        if (first_low != 658) begin
            errors++; $display("FAIL relock_hsync_start: got %0d want 658", first_low);
        end
    endtask

    // Reset coincides with the Vsync_i rise at the next frame start: reset wins.
    task automatic test_reset_edge();
        for (int n = 0; n < 20000; n++) begin
            if (urow == 0 && ucol == 0) break;
            tick();
        end
        rst_i = 1'b1;
        tick();
        checks++;
        if (Locked_o !== 1'b0) begin
            errors++; $display("FAIL edge_reset_locked: got %b want 0", Locked_o);
        end
        checks++;
        if (Hsync_o !== 1'b1 || Vsync_o !== 1'b1) begin
            errors++; $display("FAIL edge_reset_syncs: got %b%b want 11", Hsync_o, Vsync_o);
        end
        checks++;
        if ({Red_Video_o, Grn_Video_o, Blu_Video_o} !== 9'd0) begin
            errors++; $display("FAIL edge_reset_video: got %b want 0",
                               {Red_Video_o, Grn_Video_o, Blu_Video_o});
        end
        rst_i = 1'b0;
        gen   = 1'b0;
        tick();
    endtask

    initial begin
        rst_i       = 1'b1;
        Hsync_i     = 1'b0;
        Vsync_i     = 1'b0;
        Red_Video_i = 3'b000;
        Grn_Video_i = 3'b000;
        Blu_Video_i = 3'b000;
        red_c       = 3'b000;
        grn_c       = 3'b000;
        blu_c       = 3'b000;
        test_reset();
        test_hsync();
        test_video();
        test_vsync();
        test_resync();
        test_reset_midframe();
        test_reset_edge();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
